// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encodings,
// requester select codes and default parameter values.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_D  = 1'b1;

  localparam int MEM_LAT_DEFAULT = 2;
  localparam int DW_DEFAULT      = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory-side controls around the
// arbiter. The slave modport is the arbiter's view; master is the
// requester/memory side view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) ();

  logic          if_req;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          addr_sel;
  logic          mem_en;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  if_req, d_req, d_we, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, addr_sel, mem_en, mem_we, busy
  );

  modport master (
    output if_req, d_req, d_we, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, addr_sel, mem_en, mem_we, busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and
// load/store. Each grant runs a fixed MEM_LAT-cycle access followed by a
// one-cycle ack to the winner. Every output comes from registered state.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int DW      = DW_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  // The counter starts at 0 on entry to ACCESS, so this value marks the
  // final access cycle.
  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  state_t        state;
  state_t        state_next;
  logic [2:0]    cnt;
  logic          gnt;
  logic          last_grant;
  logic          we_l;
  logic          addr_sel_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          any_req;
  logic          grant_sel;

  // Round-robin winner selection and next-state decode.
  always_comb begin
    any_req    = bus.if_req | bus.d_req;
    grant_sel  = bus.d_req;
    state_next = state;
    if (bus.if_req && bus.d_req) begin
      grant_sel = ~last_grant;
    end
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (cnt == LAST_CNT) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant bookkeeping, latency counter and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 3'd0;
      gnt        <= SEL_IF;
      last_grant <= SEL_D;
      we_l       <= 1'b0;
      addr_sel_q <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt        <= grant_sel;
            last_grant <= grant_sel;
            addr_sel_q <= grant_sel;
            we_l       <= grant_sel & bus.d_we;
            cnt        <= 3'd0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 3'd1;
          if (cnt == LAST_CNT && !we_l) begin
            if (gnt == SEL_D) begin
              d_rdata_q <= bus.mem_rdata;
            end else begin
              if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_en   = (state == ACCESS);
  assign bus.mem_we   = (state == ACCESS) && we_l;
  assign bus.busy     = (state != IDLE);
  assign bus.if_ack   = (state == RESP) && (gnt == SEL_IF);
  assign bus.d_ack    = (state == RESP) && (gnt == SEL_D);
  assign bus.addr_sel = addr_sel_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule
